// File: rtl/cache_pkg.sv
// Shared cache-hierarchy definitions: line geometry, L2 arbiter state encoding
// and the request bundle used by the L1/L2 glue.
package cache_pkg;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Bit positions of the one-hot grant produced by rr_pick2.
    localparam int PICK_I = 0;
    localparam int PICK_D = 1;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } l2_req_t;

endpackage

// File: rtl/l2_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_pick2
    import cache_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_d,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant = '0;
        if (req_i && req_d) begin
            if (last_d) grant[PICK_I] = 1'b1;
            else        grant[PICK_D] = 1'b1;
        end else begin
            grant[PICK_I] = req_i;
            grant[PICK_D] = req_d;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the unified L2 request port between the I-cache and D-cache miss
// ports: round-robin grant held until L2 completes, ready/data steered back.
module l2_port_arbiter #(
    parameter int ADDR_W       = cache_pkg::ADDR_W,
    parameter int LINE_W       = cache_pkg::LINE_W,
    parameter int CNT_W        = 32,
    parameter bit FIRST_PRIO_D = 1'b1
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);
    import cache_pkg::*;

    arb_state_e state;
    logic       last_d;
    logic       mask_i;
    logic       mask_d;
    logic       req_i;
    logic       req_d;
    logic [1:0] pick;
    logic       own_i;
    logic       own_d;

    // The finisher is masked for one cycle: its L1 still shows the old request.
    assign req_i = i_read & ~mask_i;
    assign req_d = (d_read | d_write) & ~mask_d;

    rr_pick2 u_pick (
        .req_i  (req_i),
        .req_d  (req_d),
        .last_d (last_d),
        .grant  (pick)
    );

    // Owner of the L2 port this cycle; in IDLE the fresh winner drives L2 at once.
    always_comb begin
        own_i = 1'b0;
        own_d = 1'b0;
        if (!proc_reset) begin
            unique case (state)
                IDLE: begin
                    own_i = pick[PICK_I];
                    own_d = pick[PICK_D];
                end
                GNT_I:   own_i = 1'b1;
                GNT_D:   own_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign l2_read  = (own_i & i_read) | (own_d & d_read & ~d_write);
    assign l2_write = own_d & d_write;
    assign l2_addr  = own_i ? i_addr : (own_d ? d_addr : '0);
    assign l2_wdata = (own_d & d_write) ? d_wdata : '0;

    assign i_ready = own_i & l2_ready;
    assign d_ready = own_d & l2_ready;
    assign i_rdata = i_ready ? l2_rdata : '0;
    assign d_rdata = d_ready ? l2_rdata : '0;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state        <= IDLE;
            last_d       <= ~FIRST_PRIO_D;
            mask_i       <= 1'b0;
            mask_d       <= 1'b0;
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            mask_i <= 1'b0;
            mask_d <= 1'b0;
            if (state == IDLE) begin
                if (req_i && req_d) conflict_cnt <= conflict_cnt + CNT_W'(1);
                if (own_i)          i_grant_cnt  <= i_grant_cnt + CNT_W'(1);
                if (own_d)          d_grant_cnt  <= d_grant_cnt + CNT_W'(1);
            end
            if (i_ready) begin
                state  <= IDLE;
                last_d <= 1'b0;
                mask_i <= 1'b1;
            end else if (d_ready) begin
                state  <= IDLE;
                last_d <= 1'b1;
                mask_d <= 1'b1;
            end else if (state == IDLE) begin
                if (own_i)      state <= GNT_I;
                else if (own_d) state <= GNT_D;
            end
        end
    end

endmodule
